// File: rtl/sram_arbiter.sv
// Two-client arbiter and strobe sequencer for the shared asynchronous SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: client 0 priority).
module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_DOUT,
  output logic              Mem_DRIVE,
  input  logic [DATA_W-1:0] Mem_DIN,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              op_we_q;
  logic              win_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;
  logic              ce_q;
  logic              oe_q;
  logic              we_q;
  logic              drive_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              busy_q;

  logic              pick1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q;
  // On a tie, the client that did not win last time gets the bus.
  assign pick1 = c1_req & (~c0_req | ~last_q);
`else
  assign pick1 = c1_req & ~c0_req;
`endif

  assign sel_we    = pick1 ? c1_we    : c0_we;
  assign sel_addr  = pick1 ? c1_addr  : c0_addr;
  assign sel_wdata = pick1 ? c1_wdata : c0_wdata;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_we_q <= 1'b0;
      win_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drive_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (c0_req | c1_req) begin
            state_q <= ACCESS;
            win_q   <= pick1;
            op_we_q <= sel_we;
            addr_q  <= sel_addr;
            dout_q  <= sel_wdata;
            cnt_q   <= CNT_INIT;
            ce_q    <= 1'b0;
            oe_q    <= sel_we;
            we_q    <= ~sel_we;
            drive_q <= sel_we;
            busy_q  <= 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q  <= pick1;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= RECOVER;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ack0_q  <= ~win_q;
            ack1_q  <= win_q;
            if (!op_we_q) begin
              if (win_q) rd1_q <= Mem_DIN;
              else       rd0_q <= Mem_DIN;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RECOVER: begin
          // Address, data and drive stay put one cycle for hold time.
          state_q <= IDLE;
          drive_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c0_ack    = ack0_q;
  assign c1_ack    = ack1_q;
  assign c0_rdata  = rd0_q;
  assign c1_rdata  = rd1_q;
  assign Mem_ADDR  = addr_q;
  assign Mem_DOUT  = dout_q;
  assign Mem_DRIVE = drive_q;
  assign Mem_CE    = ce_q;
  assign Mem_UB    = ce_q;
  assign Mem_LB    = ce_q;
  assign Mem_OE    = oe_q;
  assign Mem_WE    = we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: transaction-level model plus a tiny SRAM.
// Covers reset, arbitration, back-to-back, withdrawn requests and reset mid-write.
module tb_sram_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int ACC = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          c0_req = 1'b0, c0_we = 1'b0;
  logic [AW-1:0] c0_addr = '0;
  logic [DW-1:0] c0_wdata = '0;
  logic          c1_req = 1'b0, c1_we = 1'b0;
  logic [AW-1:0] c1_addr = '0;
  logic [DW-1:0] c1_wdata = '0;
  logic          c0_ack, c1_ack;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [AW-1:0] Mem_ADDR;
  logic [DW-1:0] Mem_DOUT, Mem_DIN;
  logic          Mem_DRIVE, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, busy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(ACC)) dut (
    .Clk(Clk), .Reset(Reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_ack(c0_ack), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
    .Mem_ADDR(Mem_ADDR), .Mem_DOUT(Mem_DOUT), .Mem_DRIVE(Mem_DRIVE),
    .Mem_DIN(Mem_DIN), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB),
    .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] init_val(int i);
    return 16'(i * 16'h1111) ^ 16'h5a00;
  endfunction

  logic [DW-1:0] sram [8];
  logic          sram_init = 1'b0;
  logic [DW-1:0] junk = '0;

  assign Mem_DIN = Mem_OE ? junk : sram[Mem_ADDR[2:0]];

  always @(posedge Clk) begin
    junk <= 16'($urandom);
    if (Reset && !sram_init) begin
      for (int i = 0; i < 8; i++) sram[i] <= init_val(i);
      sram_init <= 1'b1;
    end else if (!Mem_WE && !Mem_CE && Mem_DRIVE) begin
      sram[Mem_ADDR[2:0]] <= Mem_DOUT;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  int            c = 0;
  int            next_free = 0;
  logic          t_act = 1'b0, t_win = 1'b0, t_we = 1'b0;
  int            t_start = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wd = '0, t_exp = '0;
  logic          ref_last = 1'b1;
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;

  logic          nreq [2];
  logic          nwe  [2];
  logic [AW-1:0] naddr[2];
  logic [DW-1:0] nwd  [2];

  task automatic gen(int k);
    nreq[k]  = 1'b1;
    nwe[k]   = 1'($urandom_range(0, 1));
    naddr[k] = AW'($urandom);
    nwd[k]   = DW'($urandom);
  endtask

  task automatic grant();
    logic w;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    w = (c0_req && c1_req) ? !ref_last : c1_req;
`else
    w = !c0_req;
`endif
    ref_last  = w;
    t_act     = 1'b1;
    t_start   = c;
    t_win     = w;
    t_we      = w ? c1_we : c0_we;
    t_addr    = w ? c1_addr : c0_addr;
    t_wd      = w ? c1_wdata : c0_wdata;
    next_free = c + ACC + 2;
    if (t_we) ref_mem[t_addr[2:0]] = t_wd;
    else      t_exp = ref_mem[t_addr[2:0]];
  endtask

  task automatic step(bit drive);
    logic acc, rec;
    logic a [2];
    logic r [2];
    acc = t_act && c > t_start && c <= t_start + ACC;
    rec = t_act && c == t_start + ACC + 1;
    if (rec && !t_we) begin
      if (t_win) exp_rd1 = t_exp;
      else       exp_rd0 = t_exp;
    end
    chk("busy",   32'(busy),      32'(acc || rec));
    chk("oe",     32'(Mem_OE),    32'(!(acc && !t_we)));
    chk("we",     32'(Mem_WE),    32'(!(acc && t_we)));
    chk("ce",     32'(Mem_CE),    32'(!acc));
    chk("ublb",   32'({Mem_UB, Mem_LB}), acc ? 32'd0 : 32'd3);
    chk("drive",  32'(Mem_DRIVE), 32'((acc || rec) && t_we));
    chk("ack0",   32'(c0_ack),    32'(rec && !t_win));
    chk("ack1",   32'(c1_ack),    32'(rec && t_win));
    chk("rdata0", 32'(c0_rdata),  32'(exp_rd0));
    chk("rdata1", 32'(c1_rdata),  32'(exp_rd1));
    if (acc || rec) begin
      chk("addr", 32'(Mem_ADDR), 32'(t_addr));
      if (t_we) chk("dout", 32'(Mem_DOUT), 32'(t_wd));
    end
    if (rec) t_act = 1'b0;
    if (c >= next_free && (c0_req || c1_req)) grant();
    if (drive) begin
      a[0] = c0_ack; a[1] = c1_ack;
      r[0] = c0_req; r[1] = c1_req;
      for (int k = 0; k < 2; k++) begin
        if (r[k] && a[k]) begin
          if ($urandom_range(0, 1) == 1) gen(k);
          else nreq[k] = 1'b0;
        end else if (!r[k] && $urandom_range(0, 2) == 0) begin
          gen(k);
        end
      end
    end
  endtask

  task automatic run(int n, bit drive);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      step(drive);
      @(posedge Clk);
      #1;
      c0_req = nreq[0]; c0_we = nwe[0];
      c0_addr = naddr[0]; c0_wdata = nwd[0];
      c1_req = nreq[1]; c1_we = nwe[1];
      c1_addr = naddr[1]; c1_wdata = nwd[1];
      c++;
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 2; i++) begin
      nreq[i] = 1'b0; nwe[i] = 1'b0; naddr[i] = '0; nwd[i] = '0;
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1f);
    chk("rst_drive", 32'(Mem_DRIVE), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_acks",  32'({c0_ack, c1_ack}), 32'd0);
    chk("rst_addr",  32'(Mem_ADDR), 32'd0);
    chk("rst_dout",  32'(Mem_DOUT), 32'd0);
    chk("rst_rd0",   32'(c0_rdata), 32'd0);
    chk("rst_rd1",   32'(c1_rdata), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    run(800, 1'b1);
    nreq[0] = 1'b0; nreq[1] = 1'b0;
    run(ACC + 4, 1'b0);
    nreq[0] = 1'b1; nwe[0] = 1'b0; naddr[0] = 20'h00123;
    nreq[1] = 1'b1; nwe[1] = 1'b0; naddr[1] = 20'h0fffc;
    run(4 * (ACC + 2) + 2, 1'b0);
    nreq[0] = 1'b0; nreq[1] = 1'b0;
    run(ACC + 4, 1'b0);

    @(posedge Clk);
    #1;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 20'h00005; c1_wdata = 16'h1234;
    @(posedge Clk);
    #1;
    chk("rw_we_lo", 32'(Mem_WE), 32'd0);
    chk("rw_drv_hi", 32'(Mem_DRIVE), 32'd1);
    Reset = 1'b1;
    c1_req = 1'b0;
    @(posedge Clk);
    #1;
    chk("rw_we",    32'(Mem_WE), 32'd1);
    chk("rw_drive", 32'(Mem_DRIVE), 32'd0);
    chk("rw_busy",  32'(busy), 32'd0);
    chk("rw_acks",  32'({c0_ack, c1_ack}), 32'd0);
    chk("rw_rd0",   32'(c0_rdata), 32'd0);
    chk("rw_rd1",   32'(c1_rdata), 32'd0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 20'h00006;
    k = 0;
    while (k < 20) begin
      @(negedge Clk);
      if (c1_ack) break;
      k++;
    end
    chk("pr_lat",   32'(k), 32'(ACC + 1));
    chk("pr_rdata", 32'(c1_rdata), 32'(ref_mem[6]));
    chk("pr_ack0",  32'(c0_ack), 32'd0);
    @(posedge Clk);
    #1 c1_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single asynchronous SRAM between two requesters: client 0 (CPU memory path) and client 1 (debug/DMA loader).
- Grants one client at a time and sequences the multi-cycle read/write strobes.
- Returns read data and a one-cycle acknowledge to the granted client.
- Sits between the CPU/loader and the SRAM pins. It replaces direct drive of Mem_OE and Mem_WE by the CPU control FSM.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACC_CYCLES, 2, cycles the OE/WE strobe is held low per access. Legal range 1..15.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- c0_req  in  1  client 0 request; level, held until c0_ack
- c0_we  in  1  client 0: 1 = write, 0 = read
- c0_addr  in  ADDR_W  client 0 address
- c0_wdata  in  DATA_W  client 0 write data
- c0_ack  out  1  client 0 completion pulse
- c0_rdata  out  DATA_W  client 0 read data, registered
- c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rdata  same as client 0, for client 1
- Mem_ADDR  out  ADDR_W  SRAM address, registered
- Mem_DOUT  out  DATA_W  write data to the top-level tri-state driver
- Mem_DRIVE  out  1  1 = top level drives the data bus with Mem_DOUT
- Mem_DIN  in  DATA_W  data bus read value
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low
- busy  out  1  arbiter not in IDLE

Behaviour:
- States: IDLE, ACCESS, RECOVER. Strobes decode from state only, so there are no output glitches from request inputs.
- Reset: state = IDLE.
  - All strobes = 1. Mem_DRIVE = 0. Both acks = 0. busy = 0.
  - Mem_ADDR, Mem_DOUT, c0_rdata, c1_rdata = 0. Access counter = 0.
- IDLE:
  - If any req is high, select the winner (see arbitration).
  - Latch the winner's addr, we and wdata into Mem_ADDR, the op register and Mem_DOUT.
  - Load counter = ACC_CYCLES-1, then go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - Mem_CE = Mem_UB = Mem_LB = 0.
  - Read: Mem_OE = 0, Mem_WE = 1, Mem_DRIVE = 0.
  - Write: Mem_WE = 0, Mem_OE = 1, Mem_DRIVE = 1.
  - Counter decrements each cycle.
  - When counter = 0: on a read, capture Mem_DIN into the winner's rdata at this clock edge; then go to RECOVER.
- RECOVER (one cycle):
  - All strobes = 1.
  - Mem_ADDR and Mem_DOUT are held, and Mem_DRIVE stays 1 for a write, to give hold time.
  - The winner's ack = 1 for exactly this cycle; the other ack stays 0.
  - Next state is IDLE.
- Latency: req sampled in IDLE at cycle T. ACCESS occupies T+1..T+ACC_CYCLES. ack is high in cycle T+ACC_CYCLES+1. Earliest next grant is T+ACC_CYCLES+2.
- Handshake:
  - A client holds req, we, addr and wdata stable until it samples ack.
  - A client drops req on the edge ending the ack cycle.
  - req still high in the following IDLE cycle counts as a new transaction.
- Request withdrawn mid-transaction: the access completes and ack is still pulsed (the client ignores it).
- rdata: holds its value until that client's next read. Writes do not change rdata.
- Arbitration (default, fixed priority):
  - If both requests are high in IDLE, client 0 wins.
  - A pending client 1 is served at the next IDLE in which c0_req is low. Starvation of client 1 is accepted in this mode.
- Inputs that change while the arbiter is not in IDLE are not sampled.
- Reset mid-operation: the next edge forces IDLE. Strobes go high and Mem_DRIVE goes low. No ack is issued and rdata is cleared.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register is updated on every grant; it resets to 1, so client 0 wins the first tie.
  - When both requests are high in IDLE, the client that is not last_grant wins.
  - A single requester always wins regardless of last_grant.
- Undefined: fixed priority to client 0 as above, and last_grant is not present.

Test Plan:
- Read, ACC_CYCLES=2: c0 read at 0x00123 with Mem_DIN=0xBEEF.
  - Mem_OE=0 for exactly 2 cycles, then c0_ack=1 for 1 cycle in cycle T+3.
  - c0_rdata=0xBEEF; c1_ack stays 0.
- Write: c1 write 0xA5A5 to 0x0FFFF.
  - Mem_WE=0 for 2 cycles with Mem_DRIVE=1 and Mem_DOUT=0xA5A5.
  - In RECOVER: Mem_WE=1 with address and data still held; c1_ack pulses; c1_rdata unchanged.
- Simultaneous requests: c0 read and c1 write both raised in the same cycle.
  - c0 is served first (ack at T+3).
  - c1 is granted at T+4 and acked at T+7.
- Back-to-back: c0 keeps req high for 3 consecutive reads.
  - Three acks spaced exactly 4 cycles apart; busy drops for one IDLE cycle between accesses.
- Reset mid-write: assert Reset in the 1st ACCESS cycle.
  - Next cycle: Mem_WE=1, Mem_DRIVE=0, busy=0, no ack.
  - A subsequent c1 read then completes normally.
- SRAM_ARB_ROUND_ROBIN_EN defined, both clients continuously requesting reads:
  - Grants alternate c0, c1, c0, c1.
  - Undefined: every grant goes to c0.
